spi_acl_responder: RTL and testbench

//  SPI mode-0 peripheral modelling the ADXL362 register interface: the responder end of our

---
 rtl/acl_regs_pkg.sv | 37 +++
 rtl/spi_edge_sync.sv | 34 +++
 rtl/spi_acl_responder.sv | 193 +++++++++++++++++++
 tb/tb_spi_acl_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acl_regs_pkg.sv
// Shared constants for the ADXL362-style SPI responder: command codes,
// register map addresses, writable window and FSM state encoding.
`timescale 1ns/1ps
package acl_regs_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [ADDR_W-1:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [ADDR_W-1:0] ADDR_PARTID    = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_XDATA     = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_YDATA     = 6'h09;
  localparam logic [ADDR_W-1:0] ADDR_ZDATA     = 6'h0A;
  localparam logic [ADDR_W-1:0] ADDR_SOFT_RST  = 6'h1F;
  localparam logic [ADDR_W-1:0] ADDR_POWER_CTL = 6'h2D;

  // Inclusive window of host-writable registers
  localparam logic [ADDR_W-1:0] WR_ADDR_LO = 6'h1F;
  localparam logic [ADDR_W-1:0] WR_ADDR_HI = 6'h2E;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } spi_state_e;

  function automatic logic addr_writable(input logic [ADDR_W-1:0] a);
    return (a >= WR_ADDR_LO) && (a <= WR_ADDR_HI);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer plus one history flop for edge detection.
// Ports: clk_i/rst_i (sync, active-high), d_i async input,
//        level_o synchronized level, rise_c/fall_c one-cycle edge pulses.
`timescale 1ns/1ps
module spi_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to 0 so a chip select held low through reset never shows a fall
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_c  = sync_q[STAGES-1] & ~prev_q;
  assign fall_c  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_acl_responder.sv
// SPI mode-0 responder emulating the ADXL362 register interface.
// Ports: CLK100MHZ/reset system side; sclk/cs/mosi async SPI inputs,
//        miso/miso_oe responder output; sample_xyz live sample bus;
//        power_ctl mirror of reg 0x2D; reg_wr_* committed-write strobe;
//        busy high whenever the FSM is outside IDLE.
`timescale 1ns/1ps
module spi_acl_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [23:0] sample_xyz,
  output logic [7:0]  power_ctl,
  output logic        reg_wr_stb,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy
);

  import acl_regs_pkg::*;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(CLK100MHZ), .rst_i(reset), .d_i(sclk),
    .level_o(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(CLK100MHZ), .rst_i(reset), .d_i(cs),
    .level_o(cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(CLK100MHZ), .rst_i(reset), .d_i(mosi),
    .level_o(mosi_lvl), .rise_c(mosi_rise), .fall_c(mosi_fall)
  );

  // Only the sclk edges and the mosi level are consumed
  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall};

  spi_state_e        state_q;
  logic              armed_q;
  logic              is_read_q;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        rx_sh_q;
  logic [6:0]        tx_sh_q;
  logic [ADDR_W-1:0] addr_q;
  logic              miso_q;
  logic              oe_q;
  logic              busy_q;
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] snap_x_q, snap_y_q, snap_z_q;
  logic [DATA_W-1:0] regs_q [64];

  logic [DATA_W-1:0] rx_byte_c;
  logic              byte_done_c;
  logic [DATA_W-1:0] rd_data_c;

  assign rx_byte_c   = {rx_sh_q, mosi_lvl};
  assign byte_done_c = sclk_rise && (bit_cnt_q == 3'd7);

  // Register read mux; anything not mapped reads back as zero
  always_comb begin
    rd_data_c = 8'h00;
    case (addr_q)
      ADDR_DEVID_AD:  rd_data_c = DEVID_AD;
      ADDR_DEVID_MST: rd_data_c = DEVID_MST;
      ADDR_PARTID:    rd_data_c = PARTID;
      ADDR_XDATA:     rd_data_c = snap_x_q;
      ADDR_YDATA:     rd_data_c = snap_y_q;
      ADDR_ZDATA:     rd_data_c = snap_z_q;
      default: begin
        if (addr_writable(addr_q)) rd_data_c = regs_q[addr_q];
      end
    endcase
  end

  // Transaction FSM, shift registers and register file
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      is_read_q <= 1'b0;
      bit_cnt_q <= 3'd0;
      rx_sh_q   <= 7'd0;
      tx_sh_q   <= 7'd0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      snap_x_q  <= '0;
      snap_y_q  <= '0;
      snap_z_q  <= '0;
      for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_stb_q <= 1'b0;
      // A frame already in progress at reset release is skipped until cs is seen high
      if (cs_lvl) armed_q <= 1'b1;

      if (state_q == ST_IDLE) begin
        if (cs_fall && armed_q) begin
          state_q   <= ST_CMD;
          busy_q    <= 1'b1;
          oe_q      <= 1'b1;
          bit_cnt_q <= 3'd0;
          rx_sh_q   <= 7'd0;
          snap_x_q  <= sample_xyz[23:16];
          snap_y_q  <= sample_xyz[15:8];
          snap_z_q  <= sample_xyz[7:0];
        end
      end else if (state_q == ST_IGNORE) begin
        miso_q <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_sh_q   <= rx_byte_c[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end

        if (byte_done_c) begin
          if (state_q == ST_CMD) begin
            if (rx_byte_c == CMD_WRITE) begin
              is_read_q <= 1'b0;
              state_q   <= ST_ADDR;
            end else if (rx_byte_c == CMD_READ) begin
              is_read_q <= 1'b1;
              state_q   <= ST_ADDR;
            end else begin
              state_q <= ST_IGNORE;
            end
          end else if (state_q == ST_ADDR) begin
            addr_q  <= rx_byte_c[ADDR_W-1:0];
            state_q <= ST_DATA;
          end else begin
            if (!is_read_q && addr_writable(addr_q)) begin
              regs_q[addr_q] <= rx_byte_c;
              wr_stb_q       <= 1'b1;
              wr_addr_q      <= addr_q;
              wr_data_q      <= rx_byte_c;
            end
            addr_q <= addr_q + 6'd1;
          end
        end

        // Byte boundary falls load a fresh byte, the rest shift it out MSB first
        if ((state_q == ST_DATA) && is_read_q && sclk_fall) begin
          if (bit_cnt_q == 3'd0) begin
            miso_q  <= rd_data_c[7];
            tx_sh_q <= rd_data_c[6:0];
          end else begin
            miso_q  <= tx_sh_q[6];
            tx_sh_q <= {tx_sh_q[5:0], 1'b0};
          end
        end
      end

      // Placed last so a coincident final rise still commits before the frame closes
      if (cs_rise) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        oe_q      <= 1'b0;
        miso_q    <= 1'b0;
        tx_sh_q   <= 7'd0;
        bit_cnt_q <= 3'd0;
      end
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = oe_q;
  assign busy        = busy_q;
  assign reg_wr_stb  = wr_stb_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign power_ctl   = regs_q[ADDR_POWER_CTL];

endmodule

// File: tb/tb_spi_acl_responder.sv
// Directed bench for spi_acl_responder: vector table of SPI frames plus
// hand sequences for snapshot coherence, aborted bytes and mid-frame reset.
`timescale 1ns/1ps
module tb_spi_acl_responder;

  localparam int unsigned H = 8;  // sclk half period in system clocks

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [23:0] sample_xyz;
  logic [7:0]  power_ctl;
  logic        reg_wr_stb;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        busy;

  spi_acl_responder dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .sample_xyz (sample_xyz),
    .power_ctl  (power_ctl),
    .reg_wr_stb (reg_wr_stb),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         stb_cnt = 0;
  logic [5:0] last_waddr = '0;
  logic [7:0] last_wdata = '0;
  bit         busy_low;

  always @(negedge clk) begin
    if (reg_wr_stb) begin
      stb_cnt++;
      last_waddr = reg_wr_addr;
      last_wdata = reg_wr_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master side: set mosi, sample miso just before each rise, fall after H clocks
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit cs_on_last,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(H);
      rx[7-i] = miso;
      if (!busy) busy_low = 1'b1;
      sclk = 1'b1;
      if (cs_on_last && (i == nbits - 1)) cs = 1'b1;
      tick(H);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                       input logic [23:0] tx, output logic [23:0] rx);
    logic [7:0] b;
    cs = 1'b0;
    tick(H);
    spi_bits(cmd, 8, 1'b0, b);
    spi_bits(addr, 8, 1'b0, b);
    rx = '0;
    for (int k = 0; k < n; k++) begin
      spi_bits(tx[23-8*k -: 8], 8, 1'b0, b);
      rx[23-8*k -: 8] = b;
    end
    tick(H);
    cs = 1'b1;
    tick(2*H);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    int          n;
    logic [23:0] tx;
    bit          chk_rx;
    logic [23:0] exp_rx;
    int          exp_stb;
    logic [5:0]  exp_waddr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_power;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    logic [23:0] rx;
    logic [7:0]  b;
    int          s0;

    vecs[0]  = '{"rd_ids",      8'h0B, 8'h00, 3, 24'h000000, 1'b1, 24'hAD1DF2, 0, 6'h00, 8'h00, 8'h00};
    vecs[1]  = '{"wr_pwr",      8'h0A, 8'h2D, 1, 24'h020000, 1'b0, 24'h000000, 1, 6'h2D, 8'h02, 8'h02};
    vecs[2]  = '{"rd_pwr",      8'h0B, 8'h2D, 1, 24'h000000, 1'b1, 24'h020000, 0, 6'h00, 8'h00, 8'h02};
    vecs[3]  = '{"bad_cmd",     8'h55, 8'h2D, 3, 24'hFFFFFF, 1'b1, 24'h000000, 0, 6'h00, 8'h00, 8'h02};
    vecs[4]  = '{"wr_ro_00",    8'h0A, 8'h00, 1, 24'h0A0000, 1'b0, 24'h000000, 0, 6'h00, 8'h00, 8'h02};
    vecs[5]  = '{"wr_wrap",     8'h0A, 8'h3F, 2, 24'h0A0A00, 1'b0, 24'h000000, 0, 6'h00, 8'h00, 8'h02};
    vecs[6]  = '{"rd_wrap",     8'h0B, 8'h3F, 2, 24'h000000, 1'b1, 24'h00AD00, 0, 6'h00, 8'h00, 8'h02};
    vecs[7]  = '{"rd_ids2",     8'h0B, 8'h00, 3, 24'h000000, 1'b1, 24'hAD1DF2, 0, 6'h00, 8'h00, 8'h02};
    vecs[8]  = '{"wr_burst",    8'h0A, 8'h2C, 2, 24'h55A500, 1'b0, 24'h000000, 2, 6'h2D, 8'hA5, 8'hA5};
    vecs[9]  = '{"rd_burst",    8'h0B, 8'h2C, 2, 24'h000000, 1'b1, 24'h55A500, 0, 6'h00, 8'h00, 8'hA5};
    vecs[10] = '{"wr_hi_edge",  8'h0A, 8'h2E, 2, 24'h334400, 1'b0, 24'h000000, 1, 6'h2E, 8'h33, 8'hA5};
    vecs[11] = '{"rd_hi_edge",  8'h0B, 8'h2E, 3, 24'h000000, 1'b1, 24'h330000, 0, 6'h00, 8'h00, 8'hA5};
    vecs[12] = '{"wr_lo_edge",  8'h0A, 8'h1E, 2, 24'h112200, 1'b0, 24'h000000, 1, 6'h1F, 8'h22, 8'hA5};
    vecs[13] = '{"rd_lo_edge",  8'h0B, 8'h1E, 2, 24'h000000, 1'b1, 24'h002200, 0, 6'h00, 8'h00, 8'hA5};
    vecs[14] = '{"rd_snap_0",   8'h0B, 8'h08, 3, 24'h000000, 1'b1, 24'h000000, 0, 6'h00, 8'h00, 8'hA5};

    reset = 1'b1;
    sclk = 1'b0;
    cs = 1'b1;
    mosi = 1'b0;
    sample_xyz = 24'h000000;
    tick(5);
    reset = 1'b0;
    tick(10);
    chk("rst_miso",    32'(miso), 32'h0);
    chk("rst_oe",      32'(miso_oe), 32'h0);
    chk("rst_busy",    32'(busy), 32'h0);
    chk("rst_stb",     32'(reg_wr_stb), 32'h0);
    chk("rst_waddr",   32'(reg_wr_addr), 32'h0);
    chk("rst_wdata",   32'(reg_wr_data), 32'h0);
    chk("rst_power",   32'(power_ctl), 32'h0);

    for (int v = 0; v < NV; v++) begin
      s0 = stb_cnt;
      busy_low = 1'b0;
      frame(vecs[v].cmd, vecs[v].addr, vecs[v].n, vecs[v].tx, rx);
      if (vecs[v].chk_rx) chk({vecs[v].name, "_rx"}, 32'(rx), 32'(vecs[v].exp_rx));
      chk({vecs[v].name, "_stb"}, 32'(stb_cnt - s0), 32'(vecs[v].exp_stb));
      if (vecs[v].exp_stb > 0) begin
        chk({vecs[v].name, "_waddr"}, 32'(last_waddr), 32'(vecs[v].exp_waddr));
        chk({vecs[v].name, "_wdata"}, 32'(last_wdata), 32'(vecs[v].exp_wdata));
      end
      chk({vecs[v].name, "_power"}, 32'(power_ctl), 32'(vecs[v].exp_power));
      chk({vecs[v].name, "_busy_hold"}, 32'(busy_low), 32'h0);
      chk({vecs[v].name, "_idle"}, 32'({busy, miso_oe, miso}), 32'h0);
    end

    // Snapshot taken at cs fall survives a sample bus change mid-frame
    sample_xyz = 24'h12F07F;
    cs = 1'b0;
    tick(H);
    sample_xyz = 24'h000000;
    chk("snap_oe", 32'(miso_oe), 32'h1);
    spi_bits(8'h0B, 8, 1'b0, b);
    spi_bits(8'h08, 8, 1'b0, b);
    spi_bits(8'h00, 8, 1'b0, b);
    chk("snap_x", 32'(b), 32'h12);
    spi_bits(8'h00, 8, 1'b0, b);
    chk("snap_y", 32'(b), 32'hF0);
    spi_bits(8'h00, 8, 1'b0, b);
    chk("snap_z", 32'(b), 32'h7F);
    tick(H);
    cs = 1'b1;
    tick(2*H);
    frame(8'h0B, 8'h08, 3, 24'h0, rx);
    chk("snap_refresh", 32'(rx), 32'h000000);

    // cs rises after 5 bits of a data byte: nothing committed
    s0 = stb_cnt;
    cs = 1'b0;
    tick(H);
    spi_bits(8'h0A, 8, 1'b0, b);
    spi_bits(8'h2D, 8, 1'b0, b);
    spi_bits(8'h00, 5, 1'b0, b);
    tick(H);
    cs = 1'b1;
    tick(2*H);
    chk("abort_stb",   32'(stb_cnt - s0), 32'h0);
    chk("abort_power", 32'(power_ctl), 32'hA5);
    chk("abort_busy",  32'(busy), 32'h0);
    chk("abort_oe",    32'(miso_oe), 32'h0);

    // cs rise coincident with the 8th rise still commits
    s0 = stb_cnt;
    cs = 1'b0;
    tick(H);
    spi_bits(8'h0A, 8, 1'b0, b);
    spi_bits(8'h2D, 8, 1'b0, b);
    spi_bits(8'h07, 8, 1'b1, b);
    tick(2*H);
    chk("coinc_stb",   32'(stb_cnt - s0), 32'h1);
    chk("coinc_waddr", 32'(last_waddr), 32'h2D);
    chk("coinc_wdata", 32'(last_wdata), 32'h07);
    chk("coinc_power", 32'(power_ctl), 32'h07);
    chk("coinc_busy",  32'(busy), 32'h0);

    // Reset mid-read, then the rest of that frame must be ignored
    s0 = stb_cnt;
    cs = 1'b0;
    tick(H);
    spi_bits(8'h0B, 8, 1'b0, b);
    spi_bits(8'h00, 8, 1'b0, b);
    spi_bits(8'h00, 4, 1'b0, b);
    tick(H);
    chk("mid_miso_pre", 32'(miso), 32'h1);
    chk("mid_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_miso",  32'(miso), 32'h0);
    chk("mid_rst_busy",  32'(busy), 32'h0);
    chk("mid_rst_oe",    32'(miso_oe), 32'h0);
    chk("mid_rst_power", 32'(power_ctl), 32'h00);
    reset = 1'b0;
    spi_bits(8'h0F, 4, 1'b0, b);
    spi_bits(8'h0A, 8, 1'b0, b);
    spi_bits(8'h2D, 8, 1'b0, b);
    spi_bits(8'hFF, 8, 1'b0, b);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_oe",   32'(miso_oe), 32'h0);
    chk("post_rst_stb",  32'(stb_cnt - s0), 32'h0);
    tick(H);
    cs = 1'b1;
    tick(2*H);
    frame(8'h0B, 8'h00, 1, 24'h0, rx);
    chk("post_rst_rd_id", 32'(rx), 32'hAD0000);
    frame(8'h0B, 8'h2D, 1, 24'h0, rx);
    chk("post_rst_rd_pwr", 32'(rx), 32'h000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
